// File: rtl/instr_encoder.sv
// instr_encoder: encodes li/add/jump requests into 8-bit words and buffers
// them in a 4-entry FIFO.
// After a jump is accepted, new requests are held off until that jump has
// left the FIFO.
// Optional feature macro: INSTR_ENC_STATS_EN adds the issue_cnt output, a
// saturating count of delivered instructions.
module instr_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [1:0] in_rd,
  input  logic [1:0] in_rs1,
  input  logic [1:0] in_rs2,
  input  logic [5:0] in_imm,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_instr,
`ifdef INSTR_ENC_STATS_EN
  output logic [7:0] issue_cnt,
`endif
  output logic       err_illegal
);

  localparam logic [1:0] OP_LI   = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  typedef enum logic {RUN, JHOLD} state_t;

  state_t     state;
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [7:0] enc_word;
  logic       accept;
  logic       push;
  logic       pop;

  // Ready depends only on registered state and occupancy.
  // A pop on a full FIFO therefore cannot free a slot in the same cycle.
  assign in_ready  = (state == RUN) && (count != 3'd4);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_op != OP_ILL);
  assign out_valid = (count != 3'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr] : 8'h00;

  // Build the instruction word from the request fields.
  always_comb begin
    enc_word = 8'h00;
    case (in_op)
      OP_LI:   enc_word = {2'b00, in_rd, in_imm[3:0]};
      OP_ADD:  enc_word = {2'b01, in_rd, in_rs1, in_rs2};
      OP_JUMP: enc_word = {2'b11, in_imm};
      default: enc_word = 8'h00;
    endcase
  end

  // Write accepted words into the FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
    end else if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Advance the FIFO pointers and occupancy.
  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // RUN/JHOLD control plus the registered illegal-op pulse.
  // While in JHOLD nothing is pushed, so the jump is always the newest entry.
  // Popping the last entry in JHOLD is therefore popping the jump itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && (in_op == OP_ILL);
      case (state)
        RUN:     if (accept && (in_op == OP_JUMP)) state <= JHOLD;
        JHOLD:   if (pop && (count == 3'd1)) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef INSTR_ENC_STATS_EN
  // Count delivered instructions, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= 8'd0;
    end else if (pop && (issue_cnt != 8'hFF)) begin
      issue_cnt <= issue_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: a scoreboard of expected words is filled by
// the driver on acceptance and drained by a monitor on output handshakes.
// Build with INSTR_ENC_STATS_EN defined to also check issue_cnt.
module tb_instr_encoder;

  typedef struct {
    logic [7:0] word;
    bit         is_jump;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic [5:0] in_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic       err_illegal;
`ifdef INSTR_ENC_STATS_EN
  logic [7:0] issue_cnt;
`endif

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   hold = 0;
  bit   pend_push = 0;
  exp_t pend_item;
  bit   pend_ill = 0;
  bit   err_exp = 0;
  bit   in_reset = 1;
  int   stat_model = 0;
  bit   acc;

  instr_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
`ifdef INSTR_ENC_STATS_EN
    .issue_cnt   (issue_cnt),
`endif
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  // Reference encoding computed arithmetically from the field layout.
  function automatic logic [7:0] model_word(int op, int rd, int rs1, int rs2, int imm);
    int w;
    w = 0;
    case (op)
      0: w = rd * 16 + (imm % 16);
      1: w = 64 + rd * 16 + rs1 * 4 + rs2;
      3: w = 192 + imm;
      default: w = 0;
    endcase
    return 8'(w);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus.
  // Pending acceptances from the previous cycle commit to the model at the
  // edge; the new request is then driven just after that edge.
  task automatic applyStimulus(input int valid, input int op, input int rd, input int rs1,
                               input int rs2, input int imm, input int ordy, output bit accepted);
    bit exp_ready;
    @(posedge clk);
    if (pend_push) begin
      sb.push_back(pend_item);
      if (pend_item.is_jump) hold = 1;
    end
    pend_push = 0;
    err_exp   = pend_ill;
    pend_ill  = 0;
    #1;
    exp_ready = !hold && (sb.size() < 4);
    checkOutput("in_ready", {7'd0, in_ready}, {7'd0, exp_ready});
    in_valid  = (valid != 0);
    in_op     = 2'(op);
    in_rd     = 2'(rd);
    in_rs1    = 2'(rs1);
    in_rs2    = 2'(rs2);
    in_imm    = 6'(imm);
    out_ready = (ordy != 0);
    accepted  = (valid != 0) && exp_ready;
    if (accepted) begin
      if (op == 2) pend_ill = 1;
      else begin
        pend_push      = 1;
        pend_item.word = model_word(op, rd, rs1, rs2, imm);
        pend_item.is_jump = (op == 3);
      end
    end
  endtask

  task automatic doReset();
    in_reset  = 1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_rd     = 2'b00;
    in_rs1    = 2'b00;
    in_rs2    = 2'b00;
    in_imm    = 6'd0;
    out_ready = 1'b0;
    sb.delete();
    hold       = 0;
    pend_push  = 0;
    pend_ill   = 0;
    err_exp    = 0;
    stat_model = 0;
    #1;
    checkOutput("rst_out_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("rst_out_instr", out_instr, 8'h00);
    checkOutput("rst_err_illegal", {7'd0, err_illegal}, 8'h00);
`ifdef INSTR_ENC_STATS_EN
    checkOutput("rst_issue_cnt", issue_cnt, 8'h00);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", {7'd0, in_ready}, 8'h01);
    in_reset = 0;
  endtask

  // Monitor: compare the FIFO head against the scoreboard.
  // The expected entry is retired whenever a handshake is about to happen.
  always @(negedge clk) begin
    exp_t item;
    if (!in_reset) begin
      checkOutput("out_valid", {7'd0, out_valid}, {7'd0, sb.size() != 0});
      checkOutput("err_illegal", {7'd0, err_illegal}, {7'd0, err_exp});
`ifdef INSTR_ENC_STATS_EN
      checkOutput("issue_cnt", issue_cnt, 8'(stat_model));
`endif
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", out_instr, 8'hxx);
        end else begin
          checkOutput("out_instr", out_instr, sb[0].word);
          if (out_ready) begin
            item = sb.pop_front();
            if (item.is_jump) hold = 0;
            if (stat_model < 255) stat_model++;
          end
        end
      end
    end
  end

  initial begin
    doReset();

    // Directed encodings with a free-running consumer.
    applyStimulus(1, 0, 2, 0, 0, 5, 1, acc);
    applyStimulus(1, 1, 1, 2, 3, 0, 1, acc);
    applyStimulus(1, 3, 2, 0, 0, 63, 1, acc);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    // Backpressure: five li requests with the consumer stalled, then drain.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, i % 4, 0, 0, 16 + i, 0, acc);
    repeat (7) applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    // Jump hold: the add behind a jump waits until the jump has been popped.
    applyStimulus(1, 3, 0, 0, 0, 21, 0, acc);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 3, 1, 2, 0, (i >= 3) ? 1 : 0, acc);
      if (acc) break;
    end
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    // Illegal op with a word parked in the FIFO.
    applyStimulus(1, 0, 1, 0, 0, 9, 0, acc);
    applyStimulus(1, 2, 3, 3, 3, 63, 0, acc);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    // Reset in the middle of a stream holding three words.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, i, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
    checkOutput("pre_reset_valid", {7'd0, out_valid}, 8'h01);
    doReset();

    // Randomised traffic with varying consumer stall rates.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        applyStimulus(($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 63),
                      ($urandom_range(0, 3) < ph + 1) ? 1 : 0, acc);
      end
    end
    repeat (8) applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    // Long stream of deliveries to push the issue counter into saturation.
    doReset();
    for (int i = 0; i < 310; i++) applyStimulus(1, 0, i % 4, 0, 0, i % 64, 1, acc);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
`ifdef INSTR_ENC_STATS_EN
    #1;
    checkOutput("issue_cnt_sat", issue_cnt, 8'(stat_model));
`endif

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  input  1  operation request valid.
REQ-004 SHALL have ports: in_ready  output  1  request accepted when in_valid&&in_ready at clk edge.
REQ-005 SHALL have ports: in_op  input  2  00=li, 01=add, 11=jump, 10=illegal.
REQ-006 SHALL have ports: in_rd  input  2  destination register; in_rs1, in_rs2  input  2 each  add sources; in_imm  input  6  li immediate / jump offset.
REQ-007 SHALL have ports: out_valid  output  1  out_instr holds a valid instruction.
REQ-008 SHALL have ports: out_ready  input  1  consumer takes out_instr when out_valid&&out_ready.
REQ-009 SHALL have ports: out_instr  output  8  encoded instruction word.
REQ-010 SHALL have ports: err_illegal  output  1  one-cycle pulse on illegal request.
REQ-011 SHALL have ports (INSTR_ENC_STATS_EN only): issue_cnt  output  8  instructions delivered.

Function
REQ-012 SHALL encode li as {2'b00, in_rd, in_imm[3:0]}; in_imm[5:4] ignored.
REQ-013 SHALL encode add as {2'b01, in_rd, in_rs1, in_rs2}.
REQ-014 SHALL encode jump as {2'b11, in_imm[5:0]}; in_rd ignored.
REQ-015 SHALL buffer encoded words in a 4-entry FIFO, delivering them in acceptance order.
REQ-016 SHALL drive out_valid = FIFO non-empty and out_instr = FIFO head; no combinational in-to-out path; minimum latency one cycle from acceptance to out_valid.
REQ-017 SHALL keep out_instr stable while out_valid&&!out_ready.
REQ-018 SHALL have a two-state FSM: RUN and JHOLD.
REQ-019 In RUN, in_ready SHALL equal FIFO not full.
REQ-020 Accepting a jump in RUN SHALL enqueue it and enter JHOLD.
REQ-021 In JHOLD, in_ready SHALL be 0.
REQ-022 The FSM SHALL return to RUN in the cycle after the jump word is popped at the output.
REQ-023 Illegal op (10) SHALL be accepted when in_ready=1, SHALL NOT be enqueued, and SHALL pulse err_illegal the following cycle.
REQ-024 When full, a simultaneous pop SHALL NOT permit a push in the same cycle (in_ready depends on occupancy only).
REQ-025 When not full, simultaneous push and pop SHALL leave occupancy unchanged.
REQ-026 Pop when empty and push when in_ready=0 SHALL have no effect.
REQ-027 FIFO pointers SHALL be 2-bit, wrapping 3->0; occupancy SHALL be a 3-bit count 0..4.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear the FIFO (occupancy 0) and set the FSM to RUN.
REQ-029 During reset, outputs SHALL be: out_valid=0, out_instr=8'h00, in_ready=1 after release, err_illegal=0, issue_cnt=0.
REQ-030 Reset mid-operation SHALL discard all buffered words, including a pending jump.

Configuration
REQ-031 With INSTR_ENC_STATS_EN defined, issue_cnt SHALL increment on each output handshake and saturate at 255.
REQ-032 Without INSTR_ENC_STATS_EN, the issue_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Encoding: li rd=2 imm=5 -> out_instr=8'h25; add rd=1 rs1=2 rs2=3 -> 8'h5B; jump imm=6'h3F -> 8'hFF.
REQ-034 Backpressure: out_ready=0, 5 li requests -> 4 accepted, in_ready=0 on the 5th; then out_ready=1 -> words delivered in order, in_ready=1 after the first pop.
REQ-035 Jump hold: jump then add presented back-to-back -> add stalled (in_ready=0) until the cycle after the jump is popped.
REQ-036 Illegal: in_op=10 -> err_illegal=1 for exactly one cycle, occupancy unchanged.
REQ-037 Reset mid-stream: 3 words buffered, rst_n pulsed low -> out_valid=0 immediately, in_ready=1 after release.
REQ-038 Stats (macro on): 300 pops -> issue_cnt=255.
